e_operand_stage: RTL

- D/E pipeline register plus E-stage operand selection for the 5-stage MIPS core.
- Latches decode-stage data and control each cycle, with stall (hold) and flush (bubble) support.
- Applies M/W forwarding to the latched register operands and drives the ALU's two operands (ari1_E, ari2_E), its 3-bit op, and the store data.
- Sits directly upstream of the E-stage ALU and feeds the E/M register.

---
 rtl/e_operand_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/e_operand_stage.sv
// rtl/e_operand_stage.sv - D/E pipeline register with M/W forwarding and ALU operand select
//
// Ports:
//   clk, reset (sync, active-low), stall (hold), flush (bubble)
//   *_D          : decode-stage data and control captured into the E stage
//   fwd_m_*      : M-stage forwarding source (wins over W)
//   fwd_w_*      : W-stage forwarding source
//   ari1_E/ari2_E: ALU operands; store_data_E: forwarded rt value
//   remaining *_E: registered copies of the decode fields for downstream stages

module e_operand_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       pc_D,
    input  logic [31:0]       instr_D,
    input  logic [RA_W-1:0]   rs_addr_D,
    input  logic [RA_W-1:0]   rt_addr_D,
    input  logic [DATA_W-1:0] rs_data_D,
    input  logic [DATA_W-1:0] rt_data_D,
    input  logic [DATA_W-1:0] imm_ext_D,
    input  logic [RA_W-1:0]   wa_D,
    input  logic [2:0]        aluop_D,
    input  logic              alusrc_D,
    input  logic              regwrite_D,
    input  logic              memwrite_D,
    input  logic [1:0]        tnew_D,
    input  logic              fwd_m_we,
    input  logic [RA_W-1:0]   fwd_m_addr,
    input  logic [DATA_W-1:0] fwd_m_data,
    input  logic              fwd_w_we,
    input  logic [RA_W-1:0]   fwd_w_addr,
    input  logic [DATA_W-1:0] fwd_w_data,
    output logic [DATA_W-1:0] ari1_E,
    output logic [DATA_W-1:0] ari2_E,
    output logic [2:0]        aluop_E,
    output logic [DATA_W-1:0] store_data_E,
    output logic [31:0]       pc_E,
    output logic [31:0]       instr_E,
    output logic [RA_W-1:0]   rs_addr_E,
    output logic [RA_W-1:0]   rt_addr_E,
    output logic [RA_W-1:0]   wa_E,
    output logic              regwrite_E,
    output logic              memwrite_E,
    output logic [1:0]        tnew_E
);

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic [DATA_W-1:0] rs_data_E;
    logic [DATA_W-1:0] rt_data_E;
    logic [DATA_W-1:0] imm_ext_E;
    logic              alusrc_E;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // Register $0 is hard-wired, so it never takes a forwarded value even
    // if a later stage claims to write it. M is younger than W and wins.
    always_comb begin
        rs_fwd = rs_data_E;
        if (rs_addr_E != '0) begin
            if (fwd_m_we && (rs_addr_E == fwd_m_addr))
                rs_fwd = fwd_m_data;
            else if (fwd_w_we && (rs_addr_E == fwd_w_addr))
                rs_fwd = fwd_w_data;
        end
    end

    always_comb begin
        rt_fwd = rt_data_E;
        if (rt_addr_E != '0) begin
            if (fwd_m_we && (rt_addr_E == fwd_m_addr))
                rt_fwd = fwd_m_data;
            else if (fwd_w_we && (rt_addr_E == fwd_w_addr))
                rt_fwd = fwd_w_data;
        end
    end

    assign ari1_E       = rs_fwd;
    assign ari2_E       = alusrc_E ? imm_ext_E : rt_fwd;
    assign store_data_E = rt_fwd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_E       <= PC_RESET;
            instr_E    <= '0;
            rs_addr_E  <= '0;
            rt_addr_E  <= '0;
            rs_data_E  <= '0;
            rt_data_E  <= '0;
            imm_ext_E  <= '0;
            wa_E       <= '0;
            aluop_E    <= '0;
            alusrc_E   <= 1'b0;
            regwrite_E <= 1'b0;
            memwrite_E <= 1'b0;
            tnew_E     <= '0;
        end else if (flush) begin
            // Bubble keeps the PC so exception/branch logic still sees where it sits.
            pc_E       <= pc_D;
            instr_E    <= '0;
            rs_addr_E  <= '0;
            rt_addr_E  <= '0;
            rs_data_E  <= '0;
            rt_data_E  <= '0;
            imm_ext_E  <= '0;
            wa_E       <= '0;
            aluop_E    <= '0;
            alusrc_E   <= 1'b0;
            regwrite_E <= 1'b0;
            memwrite_E <= 1'b0;
            tnew_E     <= '0;
        end else if (stall) begin
            // A W-stage write seen only during the stall would otherwise be
            // gone by the time the instruction resumes, so fold it in now.
            rs_data_E <= rs_fwd;
            rt_data_E <= rt_fwd;
        end else begin
            pc_E       <= pc_D;
            instr_E    <= instr_D;
            rs_addr_E  <= rs_addr_D;
            rt_addr_E  <= rt_addr_D;
            rs_data_E  <= rs_data_D;
            rt_data_E  <= rt_data_D;
            imm_ext_E  <= imm_ext_D;
            wa_E       <= wa_D;
            aluop_E    <= aluop_D;
            alusrc_E   <= alusrc_D;
            regwrite_E <= regwrite_D;
            memwrite_E <= memwrite_D;
            tnew_E     <= (tnew_D == 2'd0) ? 2'd0 : tnew_D - 2'd1;
        end
    end

endmodule
